// File: rtl/lm32_dtlb_walker_pkg.sv
// lm32_dtlb_walker_pkg: shared walker state encoding, PTE layout and page-offset helper
package lm32_dtlb_walker_pkg;

    typedef enum logic [1:0] {ST_IDLE, ST_BUS, ST_UPDATE, ST_FAULT} state_e;

    localparam int PTE_V = 0;

    function automatic int offset_width(input int page_size);
        return $clog2(page_size);
    endfunction

endpackage

// File: rtl/lm32_dtlb_walker.sv
// lm32_dtlb_walker: single-level hardware page walker that refills the LM32 DTLB on a miss
module lm32_dtlb_walker
    import lm32_dtlb_walker_pkg::*;
#(
    parameter int page_size      = 4096,
    parameter int timeout_cycles = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        enable,
    input  logic        miss_valid,
    input  logic [31:0] miss_addr,
    input  logic [31:0] ptbr,
    input  logic [31:0] d_dat_i,
    input  logic        d_ack_i,
    input  logic        d_err_i,
    output logic [31:0] d_adr_o,
    output logic        d_cyc_o,
    output logic        d_stb_o,
    output logic        tlb_we,
    output logic [31:0] tlb_vaddr,
    output logic [31:0] tlb_paddr,
    output logic        busy,
    output logic        fault,
    output logic [31:0] fault_addr
);

    localparam int          OFF_W    = offset_width(page_size);
    localparam logic [31:0] OFF_MASK = 32'(page_size - 1);
    localparam logic [7:0]  TMO      = 8'(timeout_cycles);

    state_e      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] pte_q, pte_d;
    logic [31:0] fault_addr_q, fault_addr_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        hold_q, hold_d;
    logic [31:0] vpn_full;
    logic        unused_bits;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            addr_q       <= '0;
            pte_q        <= '0;
            fault_addr_q <= '0;
            cnt_q        <= '0;
            hold_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            pte_q        <= pte_d;
            fault_addr_q <= fault_addr_d;
            cnt_q        <= cnt_d;
            hold_q       <= hold_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        pte_d   = pte_q;
        cnt_d   = cnt_q;
        hold_d  = 1'b0;
        case (state_q)
            ST_IDLE: if (enable && miss_valid && !hold_q) begin
                state_d = ST_BUS;
                addr_d  = miss_addr;
                cnt_d   = '0;
            end
            ST_BUS: begin
                cnt_d = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
                if (d_err_i) state_d = ST_FAULT;
                else if (d_ack_i) begin
                    pte_d   = d_dat_i;
                    state_d = d_dat_i[PTE_V] ? ST_UPDATE : ST_FAULT;
                end else if (cnt_d == TMO) state_d = ST_FAULT;
            end
            // The first IDLE cycle after a refill is blind so the DTLB can drop its stale miss.
            ST_UPDATE: begin
                state_d = ST_IDLE;
                hold_d  = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
        fault_addr_d = (state_q == ST_BUS && state_d == ST_FAULT) ? addr_q : fault_addr_q;
    end

    always_comb begin
        vpn_full   = addr_q >> OFF_W;
        d_cyc_o    = state_q == ST_BUS;
        d_stb_o    = d_cyc_o;
        d_adr_o    = d_cyc_o ? {ptbr[31:22], vpn_full[19:0], 2'b00} : '0;
        tlb_we     = state_q == ST_UPDATE;
        tlb_vaddr  = tlb_we ? ((addr_q & ~OFF_MASK) | 32'd1) : '0;
        tlb_paddr  = tlb_we ? ((pte_q & ~OFF_MASK) | 32'd1) : '0;
        busy       = state_q != ST_IDLE;
        fault      = state_q == ST_FAULT;
        fault_addr = fault_addr_q;
    end

    assign unused_bits = ^{ptbr[21:0], vpn_full[31:20]};

endmodule

// File: tb/tb_lm32_dtlb_walker.sv
// tb_lm32_dtlb_walker: directed self-checking bench for the DTLB page walker
module tb_lm32_dtlb_walker;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        enable;
    logic        miss_valid;
    logic [31:0] miss_addr;
    logic [31:0] ptbr;
    logic [31:0] d_dat_i;
    logic        d_ack_i;
    logic        d_err_i;
    logic [31:0] d_adr_o;
    logic        d_cyc_o;
    logic        d_stb_o;
    logic        tlb_we;
    logic [31:0] tlb_vaddr;
    logic [31:0] tlb_paddr;
    logic        busy;
    logic        fault;
    logic [31:0] fault_addr;

    int n_checks = 0;
    int n_fail   = 0;

    lm32_dtlb_walker #(.page_size(4096), .timeout_cycles(255)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .enable(enable), .miss_valid(miss_valid),
        .miss_addr(miss_addr), .ptbr(ptbr), .d_dat_i(d_dat_i), .d_ack_i(d_ack_i),
        .d_err_i(d_err_i), .d_adr_o(d_adr_o), .d_cyc_o(d_cyc_o), .d_stb_o(d_stb_o),
        .tlb_we(tlb_we), .tlb_vaddr(tlb_vaddr), .tlb_paddr(tlb_paddr), .busy(busy),
        .fault(fault), .fault_addr(fault_addr)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic start_walk(input logic [31:0] addr);
        miss_addr  = addr;
        miss_valid = 1'b1;
        tick();
        miss_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_i = 1'b1; enable = 1'b0; miss_valid = 1'b0; miss_addr = '0;
        ptbr = 32'h0040_0000; d_dat_i = '0; d_ack_i = 1'b0; d_err_i = 1'b0;
        tick(); tick();
        n_checks++;
        if ({d_cyc_o, d_stb_o, tlb_we, fault, busy} !== 5'b0) begin
            n_fail++; $display("FAIL reset_ctrl got %b expected 00000", {d_cyc_o, d_stb_o, tlb_we, fault, busy});
        end
        n_checks++;
        if ({d_adr_o, tlb_vaddr, tlb_paddr, fault_addr} !== 128'h0) begin
            n_fail++; $display("FAIL reset_data got %h %h %h %h expected zeros", d_adr_o, tlb_vaddr, tlb_paddr, fault_addr);
        end
        rst_i = 1'b0;
        tick();
    endtask

    task automatic test_disabled();
        enable = 1'b0; miss_addr = 32'h1234_5678; miss_valid = 1'b1;
        tick(); tick();
        miss_valid = 1'b0;
        n_checks++;
        if (busy !== 1'b0 || d_cyc_o !== 1'b0) begin
            n_fail++; $display("FAIL disabled_ignore got busy=%b cyc=%b expected 0 0", busy, d_cyc_o);
        end
        enable = 1'b1;
    endtask

    task automatic test_refill();
        start_walk(32'h1234_5678);
        n_checks++;
        if (d_cyc_o !== 1'b1 || d_stb_o !== 1'b1 || busy !== 1'b1) begin
            n_fail++; $display("FAIL refill_bus got cyc=%b stb=%b busy=%b expected 1 1 1", d_cyc_o, d_stb_o, busy);
        end
        n_checks++;
        if (d_adr_o !== 32'h0044_8D14) begin
            n_fail++; $display("FAIL refill_adr got %h expected 00448d14", d_adr_o);
        end
        d_dat_i = 32'h0ABC_D001; d_ack_i = 1'b1;
        tick();
        d_ack_i = 1'b0;
        n_checks++;
        if (tlb_we !== 1'b1 || d_cyc_o !== 1'b0 || fault !== 1'b0) begin
            n_fail++; $display("FAIL refill_we got we=%b cyc=%b fault=%b expected 1 0 0", tlb_we, d_cyc_o, fault);
        end
        n_checks++;
        if (tlb_vaddr !== 32'h1234_5001 || tlb_paddr !== 32'h0ABC_D001) begin
            n_fail++; $display("FAIL refill_words got %h %h expected 12345001 0abcd001", tlb_vaddr, tlb_paddr);
        end
        // a miss held high across the refill must not be taken on the first IDLE cycle
        miss_addr = 32'h0000_3000; miss_valid = 1'b1;
        tick();
        n_checks++;
        if (tlb_we !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL refill_end got we=%b busy=%b expected 0 0", tlb_we, busy);
        end
        tick();
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++; $display("FAIL refill_holdoff got busy=%b expected 0", busy);
        end
        tick();
        miss_valid = 1'b0;
        n_checks++;
        if (d_cyc_o !== 1'b1 || d_adr_o !== 32'h0040_000C) begin
            n_fail++; $display("FAIL refill_reaccept got cyc=%b adr=%h expected 1 0040000c", d_cyc_o, d_adr_o);
        end
        d_dat_i = 32'h0055_5FFF; d_ack_i = 1'b1;
        tick();
        d_ack_i = 1'b0;
        n_checks++;
        if (tlb_we !== 1'b1 || tlb_vaddr !== 32'h0000_3001 || tlb_paddr !== 32'h0055_5001) begin
            n_fail++; $display("FAIL refill2 got we=%b %h %h expected 1 00003001 00555001", tlb_we, tlb_vaddr, tlb_paddr);
        end
        tick(); tick();
    endtask

    task automatic test_invalid_pte();
        start_walk(32'h1234_5678);
        d_dat_i = 32'h0ABC_D000; d_ack_i = 1'b1;
        tick();
        d_ack_i = 1'b0;
        n_checks++;
        if (fault !== 1'b1 || tlb_we !== 1'b0 || d_cyc_o !== 1'b0) begin
            n_fail++; $display("FAIL invpte_pulse got fault=%b we=%b cyc=%b expected 1 0 0", fault, tlb_we, d_cyc_o);
        end
        n_checks++;
        if (fault_addr !== 32'h1234_5678) begin
            n_fail++; $display("FAIL invpte_addr got %h expected 12345678", fault_addr);
        end
        tick();
        n_checks++;
        if (fault !== 1'b0 || tlb_we !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL invpte_end got fault=%b we=%b busy=%b expected 0 0 0", fault, tlb_we, busy);
        end
    endtask

    task automatic test_err_priority();
        start_walk(32'h89AB_C123);
        d_dat_i = 32'h0ABC_D001; d_ack_i = 1'b1; d_err_i = 1'b1;
        tick();
        d_ack_i = 1'b0; d_err_i = 1'b0;
        n_checks++;
        if (fault !== 1'b1 || tlb_we !== 1'b0 || fault_addr !== 32'h89AB_C123) begin
            n_fail++; $display("FAIL err_prio got fault=%b we=%b addr=%h expected 1 0 89abc123", fault, tlb_we, fault_addr);
        end
        tick();
        n_checks++;
        if (tlb_we !== 1'b0 || fault !== 1'b0) begin
            n_fail++; $display("FAIL err_after got we=%b fault=%b expected 0 0", tlb_we, fault);
        end
    endtask

    task automatic test_timeout();
        int cyc_cycles = 0;
        int late_we = 0;
        start_walk(32'hCAFE_B000);
        while (d_cyc_o && cyc_cycles < 300) begin
            cyc_cycles++;
            tick();
        end
        n_checks++;
        if (cyc_cycles !== 255) begin
            n_fail++; $display("FAIL timeout_len got %0d expected 255", cyc_cycles);
        end
        n_checks++;
        if (fault !== 1'b1 || fault_addr !== 32'hCAFE_B000) begin
            n_fail++; $display("FAIL timeout_fault got fault=%b addr=%h expected 1 cafeb000", fault, fault_addr);
        end
        d_dat_i = 32'h0ABC_D001; d_ack_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            late_we += int'(tlb_we) + int'(d_cyc_o);
        end
        d_ack_i = 1'b0;
        n_checks++;
        if (late_we !== 0) begin
            n_fail++; $display("FAIL timeout_late_ack got %0d activity cycles expected 0", late_we);
        end
    endtask

    task automatic test_back_to_back();
        int cyc_rises = 1;
        logic prev_cyc;
        start_walk(32'h1234_5678);
        prev_cyc = d_cyc_o;
        miss_addr = 32'hFFFF_F000; miss_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (d_cyc_o && !prev_cyc) cyc_rises++;
            prev_cyc = d_cyc_o;
        end
        n_checks++;
        if (d_adr_o !== 32'h0044_8D14) begin
            n_fail++; $display("FAIL b2b_adr got %h expected 00448d14", d_adr_o);
        end
        d_dat_i = 32'h0ABC_D001; d_ack_i = 1'b1;
        tick();
        d_ack_i = 1'b0; miss_valid = 1'b0;
        n_checks++;
        if (tlb_we !== 1'b1 || tlb_vaddr !== 32'h1234_5001) begin
            n_fail++; $display("FAIL b2b_we got we=%b vaddr=%h expected 1 12345001", tlb_we, tlb_vaddr);
        end
        prev_cyc = d_cyc_o;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (d_cyc_o && !prev_cyc) cyc_rises++;
            prev_cyc = d_cyc_o;
        end
        n_checks++;
        if (cyc_rises !== 1) begin
            n_fail++; $display("FAIL b2b_cycles got %0d bus cycles expected 1", cyc_rises);
        end
    endtask

    task automatic test_enable_drop();
        start_walk(32'h0000_5123);
        enable = 1'b0;
        d_dat_i = 32'h0077_7001; d_ack_i = 1'b1;
        tick();
        d_ack_i = 1'b0;
        n_checks++;
        if (tlb_we !== 1'b1 || tlb_paddr !== 32'h0077_7001 || tlb_vaddr !== 32'h0000_5001) begin
            n_fail++; $display("FAIL endrop got we=%b %h %h expected 1 00005001 00777001", tlb_we, tlb_vaddr, tlb_paddr);
        end
        enable = 1'b1;
        tick(); tick();
    endtask

    task automatic test_reset_mid_bus();
        int late_we = 0;
        start_walk(32'h1234_5678);
        tick();
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        n_checks++;
        if (d_cyc_o !== 1'b0 || busy !== 1'b0 || d_adr_o !== 32'h0) begin
            n_fail++; $display("FAIL rstbus got cyc=%b busy=%b adr=%h expected 0 0 0", d_cyc_o, busy, d_adr_o);
        end
        d_dat_i = 32'h0ABC_D001; d_ack_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            late_we += int'(tlb_we) + int'(fault);
        end
        d_ack_i = 1'b0;
        n_checks++;
        if (late_we !== 0) begin
            n_fail++; $display("FAIL rstbus_late_ack got %0d activity cycles expected 0", late_we);
        end
    endtask

    initial begin
        test_reset();
        test_disabled();
        test_refill();
        test_invalid_pte();
        test_err_priority();
        test_timeout();
        test_back_to_back();
        test_enable_drop();
        test_reset_mid_bus();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
